// File: rtl/regfile_wr_arbiter_if.sv
// rtl/regfile_wr_arbiter_if.sv - write-back request, register-file write and scoreboard bus
interface regfile_wr_arbiter_if;
    logic        REQ_A;
    logic        REQ_B;
    logic [4:0]  ADDR_A;
    logic [4:0]  ADDR_B;
    logic [31:0] DATA_A;
    logic [31:0] DATA_B;
    logic        GNT_A;
    logic        GNT_B;
    logic        WRITE_ENABLE;
    logic [4:0]  WRITE_REG;
    logic [31:0] DATA_IN;
    logic        RESERVE_EN;
    logic [4:0]  RESERVE_REG;
    logic [4:0]  READ_REG1;
    logic [4:0]  READ_REG2;
    logic        BUSY1;
    logic        BUSY2;

    // Pipeline side: requesters and decode
    modport master (
        output REQ_A, REQ_B, ADDR_A, ADDR_B, DATA_A, DATA_B,
        output RESERVE_EN, RESERVE_REG, READ_REG1, READ_REG2,
        input  GNT_A, GNT_B, WRITE_ENABLE, WRITE_REG, DATA_IN, BUSY1, BUSY2
    );

    // Arbiter side
    modport slave (
        input  REQ_A, REQ_B, ADDR_A, ADDR_B, DATA_A, DATA_B,
        input  RESERVE_EN, RESERVE_REG, READ_REG1, READ_REG2,
        output GNT_A, GNT_B, WRITE_ENABLE, WRITE_REG, DATA_IN, BUSY1, BUSY2
    );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - two-port round-robin write-back arbiter with pending-register scoreboard
module regfile_wr_arbiter #(
    parameter int NREG = 32
) (
    input  logic                 CLK,
    input  logic                 RSTa,
    regfile_wr_arbiter_if.slave  bus
);

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

    logic            last_q, last_d;
    logic            we_q, we_d;
    logic [4:0]      wreg_q, wreg_d;
    logic [31:0]     data_q, data_d;
    logic [NREG-1:0] pend_q, pend_d;

    logic            gnt_a, gnt_b;
    logic [4:0]      gnt_addr;
    logic [31:0]     gnt_data;

    // Round-robin grant; reset low masks grants so nothing in flight is written
    always_comb begin
        gnt_a = RSTa & bus.REQ_A & (~bus.REQ_B | (last_q == SEL_B));
        gnt_b = RSTa & bus.REQ_B & (~bus.REQ_A | (last_q == SEL_A));
        gnt_addr = gnt_b ? bus.ADDR_B : bus.ADDR_A;
        gnt_data = gnt_b ? bus.DATA_B : bus.DATA_A;
    end

    assign bus.GNT_A        = gnt_a;
    assign bus.GNT_B        = gnt_b;
    assign bus.WRITE_ENABLE = we_q;
    assign bus.WRITE_REG    = wreg_q;
    assign bus.DATA_IN      = data_q;

    // Next write-port state; x0 writes are granted but never issued, and the
    // port holds its last values whenever no write is issued
    always_comb begin
        last_d = last_q;
        we_d   = 1'b0;
        wreg_d = wreg_q;
        data_d = data_q;
        if (gnt_a || gnt_b) begin
            last_d = gnt_b ? SEL_B : SEL_A;
            if (gnt_addr != 5'd0) begin
                we_d   = 1'b1;
                wreg_d = gnt_addr;
                data_d = gnt_data;
            end
        end
    end

    // Pending vector: retire clears, reserve sets afterwards so it wins a tie
    always_comb begin
        pend_d = pend_q;
        if (we_q) begin
            pend_d[wreg_q] = 1'b0;
        end
        if (bus.RESERVE_EN && (bus.RESERVE_REG != 5'd0)) begin
            pend_d[bus.RESERVE_REG] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    // Source busy: pending, or being written this very cycle (bypass of the clear)
    always_comb begin
        bus.BUSY1 = pend_q[bus.READ_REG1] |
                    (we_q && (wreg_q == bus.READ_REG1) && (bus.READ_REG1 != 5'd0));
        bus.BUSY2 = pend_q[bus.READ_REG2] |
                    (we_q && (wreg_q == bus.READ_REG2) && (bus.READ_REG2 != 5'd0));
    end

    // State registers; reset leaves LAST=B so A wins the first conflict
    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            last_q <= SEL_B;
            we_q   <= 1'b0;
            wreg_q <= 5'd0;
            data_q <= 32'd0;
            pend_q <= '0;
        end else begin
            last_q <= last_d;
            we_q   <= we_d;
            wreg_q <= wreg_d;
            data_q <= data_d;
            pend_q <= pend_d;
        end
    end

endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter NREG, default 32, number of architectural registers tracked (fixed 32; 5-bit indices).
REQ-002 SHALL have port CLK  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port RSTa  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports REQ_A, REQ_B  input  1  write-back request from ALU (A) and load unit (B).
REQ-005 SHALL have ports ADDR_A, ADDR_B  input  5  destination register of each request.
REQ-006 SHALL have ports DATA_A, DATA_B  input  32  write data of each request.
REQ-007 SHALL have ports GNT_A, GNT_B  output  1  combinational grant, same cycle as request.
REQ-008 SHALL have ports WRITE_ENABLE  output  1, WRITE_REG  output  5, DATA_IN  output  32  registered register-file write port.
REQ-009 SHALL have ports RESERVE_EN  input  1, RESERVE_REG  input  5  decode marks destination as pending.
REQ-010 SHALL have ports READ_REG1, READ_REG2  input  5  source registers under decode.
REQ-011 SHALL have ports BUSY1, BUSY2  output  1  source register has an outstanding write.

Function
REQ-012 SHALL grant at most one requester per cycle; GNT_x only when REQ_x=1.
REQ-013 SHALL arbitrate round-robin: pointer LAST records last granted requester; on conflict, the requester other than LAST wins.
REQ-014 SHALL update LAST only on cycles with a grant; single requester always granted immediately.
REQ-015 SHALL require a denied requester to hold REQ/ADDR/DATA stable until granted; no request is dropped.
REQ-016 SHALL register the granted ADDR/DATA: WRITE_ENABLE=1, WRITE_REG, DATA_IN valid exactly one cycle after grant (latency 1), for one cycle.
REQ-017 SHALL grant requests targeting x0 but keep WRITE_ENABLE=0 the following cycle.
REQ-018 SHALL hold WRITE_REG/DATA_IN at last values when WRITE_ENABLE=0.
REQ-019 SHALL keep a 32-bit pending vector PEND; bit 0 permanently 0.
REQ-020 SHALL set PEND[RESERVE_REG] on RESERVE_EN=1 (ignored for x0).
REQ-021 SHALL clear PEND[WRITE_REG] in the cycle WRITE_ENABLE=1.
REQ-022 SHALL give set priority when reserve and clear hit the same register in one cycle.
REQ-023 SHALL drive BUSYn = PEND[READ_REGn] OR (WRITE_ENABLE AND WRITE_REG==READ_REGn AND READ_REGn!=0), combinationally.
REQ-024 SHALL allow back-to-back grants every cycle; sustained conflict alternates A,B,A,B.

Reset
REQ-025 SHALL on RSTa=0, asynchronously: WRITE_ENABLE=0, WRITE_REG=0, DATA_IN=0, PEND=0, LAST=B (A wins first conflict).
REQ-026 SHALL drive GNT_A=GNT_B=0 while RSTa=0; a grant in flight when reset asserts is discarded, no write issued.
REQ-027 SHALL resume arbitration on the first rising CLK edge after RSTa deasserts.

Verification
REQ-028 SHALL cover: after reset, REQ_A and REQ_B both 1 (ADDR_A=5, DATA_A=0x11; ADDR_B=6, DATA_B=0x22) -> GNT_A cycle 0, write x5=0x11 cycle 1; GNT_B cycle 1, write x6=0x22 cycle 2.
REQ-029 SHALL cover: both requesting continuously for 4 grants -> grant order A,B,A,B, one WRITE_ENABLE per cycle.
REQ-030 SHALL cover: REQ_B alone with ADDR_B=0, DATA_B=0xFFFFFFFF -> GNT_B=1, WRITE_ENABLE stays 0.
REQ-031 SHALL cover: RESERVE x7, READ_REG1=7 -> BUSY1=1 until write to x7 retires; same cycle as that write, a new RESERVE x7 -> BUSY1 remains 1.
REQ-032 SHALL cover: RSTa pulsed low mid-cycle with REQ_A granted -> WRITE_ENABLE=0 next edge, PEND=0, BUSY1=BUSY2=0.
